// File: rtl/mac_vlg_tx_arb_pkg.sv
// Shared MAC TX arbiter types and frame constants.
package mac_vlg_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, XMIT, IFG} tx_arb_fsm_t;

  localparam int MAC_IFG_BYTES   = 12;
  localparam int MAC_MAX_FRAME   = 1518;
  localparam int MAC_GNT_TIMEOUT = 64;

  // Index width that stays at least one bit for single-entry vectors.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mac_vlg_tx_arb_if.sv
// Requester-side and MAC-side signals of the TX arbiter, bundled for port use.
interface mac_vlg_tx_arb_if
  import mac_vlg_pkg::*;
#(
  parameter int N = 3
);
  localparam int SEL_W = idx_width(N);

  logic [N-1:0]     req;
  logic [N-1:0]     gnt;
  logic [N*8-1:0]   data_in;
  logic [N-1:0]     valid_in;
  logic [N-1:0]     last_in;
  logic [7:0]       data_out;
  logic             valid_out;
  logic             last_out;
  logic             error_out;
  logic [SEL_W-1:0] sel;
  logic             busy;

  modport master (
    output req, data_in, valid_in, last_in,
    input  gnt, data_out, valid_out, last_out, error_out, sel, busy
  );

  modport slave (
    input  req, data_in, valid_in, last_in,
    output gnt, data_out, valid_out, last_out, error_out, sel, busy
  );

endinterface

// File: rtl/mac_vlg_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module mac_vlg_rr_pick
  import mac_vlg_pkg::*;
#(
  parameter int N     = 3,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     pick_o,
  output logic [IDX_W-1:0] index_o,
  output logic             any_o
);

  int   cand;
  logic found;

  always_comb begin
    pick_o  = '0;
    index_o = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr_i) + k) % N;
      if (!found && req_i[cand]) begin
        found        = 1'b1;
        pick_o[cand] = 1'b1;
        index_o      = IDX_W'(cand);
      end
    end
  end

  assign any_o = found;

endmodule

// File: rtl/mac_vlg_tx_arb.sv
// Frame-level round-robin arbiter feeding the MAC TX byte stream, with IFG,
// grant timeout and maximum-length truncation.
module mac_vlg_tx_arb
  import mac_vlg_pkg::*;
#(
  parameter int N       = 3,
  parameter int IFG     = MAC_IFG_BYTES,
  parameter int MAX_LEN = MAC_MAX_FRAME,
  parameter int TIMEOUT = MAC_GNT_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst_n,
  mac_vlg_tx_arb_if.slave tx
);

  localparam int SEL_W = idx_width(N);
  localparam int BC_W  = $clog2(MAX_LEN + 1);
  localparam int TO_W  = idx_width(TIMEOUT);
  localparam int IG_W  = idx_width(IFG);

  // With a zero gap a finished frame returns straight to arbitration.
  localparam tx_arb_fsm_t POST_ST   =
    tx_arb_fsm_t'((IFG > 0) ? mac_vlg_pkg::IFG : mac_vlg_pkg::IDLE);
  localparam logic        POST_BUSY = (IFG > 0);

  tx_arb_fsm_t      state_q;
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] ptr_d;
  logic [SEL_W-1:0] sel_q;
  logic [N-1:0]     gnt_q;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             last_q;
  logic             err_q;
  logic             busy_q;
  logic [BC_W-1:0]  byte_cnt_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic [IG_W-1:0]  ifg_cnt_q;

  logic [N-1:0]     pick;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_any;

  logic [7:0]       cur_byte;
  logic             cur_vld;
  logic             cur_lst;
  logic             cur_req;
  logic             at_max;

  function automatic logic [BC_W-1:0] sat_inc(input logic [BC_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  mac_vlg_rr_pick #(
    .N     (N),
    .IDX_W (SEL_W)
  ) u_pick (
    .req_i   (tx.req),
    .ptr_i   (ptr_q),
    .pick_o  (pick),
    .index_o (pick_idx),
    .any_o   (pick_any)
  );

  // Only the granted requester's lane is ever looked at.
  always_comb begin
    cur_byte = '0;
    cur_vld  = 1'b0;
    cur_lst  = 1'b0;
    cur_req  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel_q == SEL_W'(i)) begin
        cur_byte = tx.data_in[8*i +: 8];
        cur_vld  = tx.valid_in[i];
        cur_lst  = tx.last_in[i];
        cur_req  = tx.req[i];
      end
    end
  end

  assign ptr_d  = (int'(sel_q) >= N - 1) ? '0 : sel_q + 1'b1;
  assign at_max = (byte_cnt_q == BC_W'(MAX_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= mac_vlg_pkg::IDLE;
      ptr_q      <= '0;
      sel_q      <= '0;
      gnt_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      byte_cnt_q <= '0;
      to_cnt_q   <= '0;
      ifg_cnt_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        mac_vlg_pkg::IDLE: begin
          if (pick_any) begin
            gnt_q      <= pick;
            sel_q      <= pick_idx;
            byte_cnt_q <= '0;
            to_cnt_q   <= '0;
            busy_q     <= 1'b1;
            state_q    <= mac_vlg_pkg::GRANT;
          end
        end

        mac_vlg_pkg::GRANT, mac_vlg_pkg::XMIT: begin
          if (cur_vld) begin
            data_q     <= cur_byte;
            valid_q    <= 1'b1;
            last_q     <= cur_lst | at_max;
            byte_cnt_q <= sat_inc(byte_cnt_q);
            if (cur_lst || at_max) begin
              // A length overrun is closed with a forced last and flagged.
              err_q     <= ~cur_lst;
              gnt_q     <= '0;
              ptr_q     <= ptr_d;
              ifg_cnt_q <= '0;
              busy_q    <= POST_BUSY;
              state_q   <= POST_ST;
            end else begin
              state_q <= mac_vlg_pkg::XMIT;
            end
          end else if (state_q == mac_vlg_pkg::XMIT) begin
            err_q     <= 1'b1;
            gnt_q     <= '0;
            ptr_q     <= ptr_d;
            ifg_cnt_q <= '0;
            busy_q    <= POST_BUSY;
            state_q   <= POST_ST;
          end else if (!cur_req) begin
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= mac_vlg_pkg::IDLE;
          end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            gnt_q   <= '0;
            ptr_q   <= ptr_d;
            busy_q  <= 1'b0;
            state_q <= mac_vlg_pkg::IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end

        mac_vlg_pkg::IFG: begin
          if (ifg_cnt_q == IG_W'(IFG - 1)) begin
            busy_q  <= 1'b0;
            state_q <= mac_vlg_pkg::IDLE;
          end else begin
            ifg_cnt_q <= ifg_cnt_q + 1'b1;
          end
        end

        default: begin
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= mac_vlg_pkg::IDLE;
        end
      endcase
    end
  end

  assign tx.gnt       = gnt_q;
  assign tx.sel       = sel_q;
  assign tx.data_out  = data_q;
  assign tx.valid_out = valid_q;
  assign tx.last_out  = last_q;
  assign tx.error_out = err_q;
  assign tx.busy      = busy_q;

endmodule

// File: tb/tb_mac_vlg_tx_arb.sv
// Directed bench for mac_vlg_tx_arb with N=3, IFG=12, MAX_LEN=1518, TIMEOUT=64.
module tb_mac_vlg_tx_arb;

  localparam int N  = 3;
  localparam int DW = N * 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  always #5 clk = ~clk;

  mac_vlg_tx_arb_if #(.N(N)) bus ();

  mac_vlg_tx_arb #(
    .N       (N),
    .IFG     (12),
    .MAX_LEN (1518),
    .TIMEOUT (64)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tx    (bus)
  );

  task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame on lane r (grant already visible), noise on other lanes.
  task automatic xmit(input int r, input int n, input bit fin, input logic [7:0] base);
    logic [7:0] d;
    for (int b = 0; b < n; b++) begin
      d = base + 8'(b);
      bus.data_in  = DW'($urandom);
      bus.valid_in = N'($urandom);
      bus.last_in  = N'($urandom);
      bus.data_in[8*r +: 8] = d;
      bus.valid_in[r] = 1'b1;
      bus.last_in[r]  = fin && (b == n - 1);
      step();
      check_vec("xmit_data",  bus.data_out,  d);
      check_vec("xmit_valid", bus.valid_out, 1);
      check_vec("xmit_last",  bus.last_out,  (fin && (b == n - 1)) ? 1 : 0);
      check_vec("xmit_err",   bus.error_out, 0);
    end
    bus.data_in  = '0;
    bus.valid_in = '0;
    bus.last_in  = '0;
  endtask

  task automatic wait_gnt(input string tag, input logic [2:0] exp_g);
    int n;
    n = 0;
    while (bus.gnt == '0 && n < 60) begin
      step();
      n++;
    end
    check_vec({tag, "_gap"}, n - 1, 12);
    check_vec({tag, "_gnt"}, bus.gnt, exp_g);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    int late;
    bus.req      = '0;
    bus.data_in  = '0;
    bus.valid_in = '0;
    bus.last_in  = '0;

    // Reset state
    #12;
    check_vec("rst_gnt",   bus.gnt,       0);
    check_vec("rst_valid", bus.valid_out, 0);
    check_vec("rst_last",  bus.last_out,  0);
    check_vec("rst_err",   bus.error_out, 0);
    check_vec("rst_busy",  bus.busy,      0);
    check_vec("rst_sel",   bus.sel,       0);
    check_vec("rst_data",  bus.data_out,  0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single 64-byte frame from requester 0
    bus.req = 3'b001;
    check_vec("t1_gnt_pre", bus.gnt, 0);
    step();
    check_vec("t1_gnt", bus.gnt, 3'b001);
    check_vec("t1_busy", bus.busy, 1);
    xmit(0, 64, 1'b1, 8'h00);
    check_vec("t1_gnt_clr", bus.gnt, 0);
    bus.req = '0;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.busy !== 1'b1 || bus.error_out !== 1'b0) bad++;
      step();
    end
    check_vec("t1_ifg_busy", bad, 0);
    check_vec("t1_idle_busy", bus.busy, 0);

    // Round robin with all three requesting
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.req = 3'b111;
    step();
    check_vec("rr0_gnt", bus.gnt, 3'b001);
    xmit(0, 10, 1'b1, 8'h10);
    wait_gnt("rr1", 3'b010);
    xmit(1, 10, 1'b1, 8'h20);
    wait_gnt("rr2", 3'b100);
    xmit(2, 10, 1'b1, 8'h30);
    wait_gnt("rr3", 3'b001);
    xmit(0, 10, 1'b1, 8'h40);
    bus.req = 3'b110;
    wait_gnt("to_pre", 3'b010);

    // Grant timeout on requester 1
    n = 0;
    while (bus.error_out !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check_vec("to_cycles", n, 64);
    check_vec("to_gnt_clr", bus.gnt, 0);
    check_vec("to_busy", bus.busy, 0);
    step();
    check_vec("to_err_pulse", bus.error_out, 0);
    check_vec("to_next_gnt", bus.gnt, 3'b100);
    check_vec("to_next_sel", bus.sel, 2);

    // Requester 2 drops valid mid-frame
    bus.req = 3'b101;
    xmit(2, 20, 1'b0, 8'h80);
    step();
    check_vec("drop_valid", bus.valid_out, 0);
    check_vec("drop_err",   bus.error_out, 1);
    check_vec("drop_last",  bus.last_out,  0);
    check_vec("drop_gnt",   bus.gnt,       0);
    check_vec("drop_busy",  bus.busy,      1);
    wait_gnt("drop", 3'b001);

    // Requester 0 overruns the maximum frame length
    bus.req = 3'b001;
    bad  = 0;
    late = 0;
    for (int b = 0; b < 1600; b++) begin
      bus.data_in  = '0;
      bus.data_in[7:0] = 8'(b);
      bus.valid_in = 3'b001;
      bus.last_in  = '0;
      step();
      if (b < 1517) begin
        if (bus.data_out !== 8'(b) || bus.valid_out !== 1'b1 ||
            bus.last_out !== 1'b0 || bus.error_out !== 1'b0) bad++;
      end else if (b == 1517) begin
        check_vec("trunc_data",  bus.data_out,  8'hED);
        check_vec("trunc_valid", bus.valid_out, 1);
        check_vec("trunc_last",  bus.last_out,  1);
        check_vec("trunc_err",   bus.error_out, 1);
        check_vec("trunc_gnt",   bus.gnt,       0);
        bus.req = '0;
      end else begin
        if (bus.valid_out !== 1'b0 || bus.last_out !== 1'b0 ||
            bus.error_out !== 1'b0 || bus.gnt !== 3'b000) late++;
      end
    end
    bus.valid_in = '0;
    bus.data_in  = '0;
    check_vec("trunc_body", bad, 0);
    check_vec("trunc_after", late, 0);

    // Asynchronous reset in the middle of a frame
    bus.req = 3'b011;
    step();
    check_vec("mid_gnt", bus.gnt, 3'b010);
    xmit(1, 5, 1'b0, 8'hA0);
    bus.valid_in[1] = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    check_vec("arst_gnt",   bus.gnt,       0);
    check_vec("arst_valid", bus.valid_out, 0);
    check_vec("arst_busy",  bus.busy,      0);
    check_vec("arst_sel",   bus.sel,       0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.valid_in = '0;
    step();
    check_vec("arst_ptr_gnt", bus.gnt, 3'b001);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
